// File: rtl/hex_display_mux_if.sv
// Bus between a display-data source and hex_display_mux.
//
// Control and data signals:
//   Enable            source -> mux  scan enable
//   Load              source -> mux  one-cycle strobe capturing Value/DpIn
//   Value             source -> mux  4 bits per digit, Value[3:0] = digit 0
//   DpIn              source -> mux  decimal point per digit, 1 = lit
//   BlankLeadingZeros source -> mux  1 = suppress leading zero digits
//   SegOut            mux -> board   active-low segments a..g (bits 0..6), dp (bit 7)
//   DigitSel          mux -> board   one-hot digit select
//   ScanDone          mux -> source  one-cycle pulse after each frame wrap
//
// Load is a single-cycle strobe with no back-pressure: every cycle with
// Load=1 is a transfer, and the mux always accepts it (no ready signal).
interface hex_display_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      Enable;
  logic                      Load;
  logic [4*NUM_DIGITS-1:0]   Value;
  logic [NUM_DIGITS-1:0]     DpIn;
  logic                      BlankLeadingZeros;
  logic [7:0]                SegOut;
  logic [NUM_DIGITS-1:0]     DigitSel;
  logic                      ScanDone;

  modport master (
    output Enable, Load, Value, DpIn, BlankLeadingZeros,
    input  SegOut, DigitSel, ScanDone
  );

  modport slave (
    input  Enable, Load, Value, DpIn, BlankLeadingZeros,
    output SegOut, DigitSel, ScanDone
  );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYCLES of a slot
// drive everything off to avoid ghosting. Display data is double-buffered:
// Load fills a pending register that is copied to the active register at
// each frame wrap (or every cycle while Enable=0).
//
// Ports:
//   Clock   rising-edge system clock
//   ResetN  asynchronous active-low reset
//   bus     hex_display_mux_if slave (Enable/Load/Value/DpIn/
//           BlankLeadingZeros in, SegOut/DigitSel/ScanDone out)
//
// All outputs are registered and reflect the scan state (idx, cnt) of the
// previous cycle.
module hex_display_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input logic             Clock,
  input logic             ResetN,
  hex_display_mux_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic                  ACT_LOW   = (DIGIT_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = {NUM_DIGITS{ACT_LOW}};
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  done_q, done_d;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  upper_zero;
  logic                  blank_digit;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h67;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    wrap        = slot_end && (idx_q == IDX_LAST);

    // Walk from the most significant digit down so that upper_zero means
    // "nibbles k..NUM_DIGITS-1 are all zero" when digit k is examined.
    nib         = 4'h0;
    dp_bit      = 1'b0;
    onehot      = '0;
    upper_zero  = 1'b1;
    blank_digit = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (act_val_q[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      if (idx_q == IDX_W'(k)) begin
        nib         = act_val_q[4*k +: 4];
        dp_bit      = act_dp_q[k];
        onehot[k]   = 1'b1;
        blank_digit = bus.BlankLeadingZeros && (k != 0) && upper_zero;
      end
    end

    pend_val_d = bus.Load ? bus.Value : pend_val_q;
    pend_dp_d  = bus.Load ? bus.DpIn  : pend_dp_q;

    // Load coinciding with a buffer swap bypasses the pending register.
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (!bus.Enable || wrap) begin
      act_val_d = bus.Load ? bus.Value : pend_val_q;
      act_dp_d  = bus.Load ? bus.DpIn  : pend_dp_q;
    end

    if (!bus.Enable) begin
      cnt_d  = '0;
      idx_d  = '0;
      seg_d  = 8'hFF;
      sel_d  = SEL_OFF;
      done_d = 1'b0;
    end else begin
      cnt_d  = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d  = wrap ? '0 : (slot_end ? idx_q + IDX_W'(1) : idx_q);
      done_d = wrap;
      if (cnt_q < CNT_BLANK) begin
        seg_d = 8'hFF;
        sel_d = SEL_OFF;
      end else begin
        seg_d = {~dp_bit, blank_digit ? 7'h7F : ~glyph(nib)};
        sel_d = ACT_LOW ? ~onehot : onehot;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= 8'hFF;
      sel_q      <= SEL_OFF;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
    end
  end

  assign bus.SegOut   = seg_q;
  assign bus.DigitSel = sel_q;
  assign bus.ScanDone = done_q;

endmodule
